ram_sp_fifo_ctrl: RTL and testbench
===================================

Name: ram_sp_fifo_ctrl

Overview:
- Upstream controller that turns the single-port RAM (5-bit data, 16 entries) into a FIFO.
- Accepts push and pop requests, arbitrates them onto the RAM's one addr/we/din port, and returns popped data from the RAM's dout.
- Holds the read/write pointers, the occupancy count and the full/empty flags. The RAM itself stays a separate instance.

Parameters:
- DW, 5, data width; matches the RAM word width.
- AW, 4, address width; matches the RAM address width.
- DEPTH, 16, number of entries; equals 2**AW.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO contents.
- wr_en  input  1  push request; wr_data is valid while high.
- wr_data  input  DW  push data.
- wr_ack  output  1  push granted this cycle; the word is written at this edge.
- rd_en  input  1  pop request.
- rd_ack  output  1  pop granted this cycle.
- rd_valid  output  1  popped data present on rd_data; asserted the cycle after rd_ack.
- rd_data  output  DW  popped data; equals ram_dout while rd_valid.
- ram_addr  output  AW  RAM address.
- ram_we  output  1  RAM write enable.
- ram_din  output  DW  RAM write data.
- ram_dout  input  DW  RAM read data; valid one cycle after the address is presented with ram_we=0.
- count  output  AW+1  occupancy, range 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.

Behaviour:
- Reset (rst=1):
  - wptr, rptr and count go to 0.
  - The prio flag goes to 0 (write favoured).
  - rd_valid goes to 0 on the next edge.
  - Combinational outputs while rst=1: wr_ack=0, rd_ack=0, ram_we=0.
  - Resulting flag values: empty=1, full=0.
- Eligibility: a push is eligible when wr_en && !full. A pop is eligible when rd_en && !empty.
- Arbitration (combinational, at most one grant per cycle):
  - Only push eligible -> push granted. Only pop eligible -> pop granted.
  - Both eligible -> prio=0 grants push, prio=1 grants pop.
  - The prio flag toggles only on a cycle where both were eligible, so the two sides alternate under contention.
  - No grants while rst or flush is high.
- Push grant:
  - wr_ack=1, ram_we=1, ram_addr=wptr, ram_din=wr_data.
  - At the edge: wptr increments (mod DEPTH) and count increments.
- Pop grant:
  - rd_ack=1, ram_we=0, ram_addr=rptr.
  - At the edge: rptr increments (mod DEPTH), count decrements, and the rd_valid register is set.
  - Next cycle: rd_valid=1 and rd_data=ram_dout.
  - Pop latency is 1 cycle, from the rd_ack cycle to the data cycle.
- Idle cycle: ram_we=0, ram_addr=rptr, ram_din=wr_data. No state change except rd_valid clearing.
- Flags and pointers:
  - full and empty are decoded from the registered count.
  - A push and a pop never update count on the same edge, because the RAM has a single port.
  - Pointers are AW bits and wrap from 15 to 0.
- Ungranted requests have no side effects. The requester holds wr_en/wr_data or rd_en until it sees the ack.
- flush:
  - Same clear as rst except the prio flag is kept.
  - Clears a pending rd_valid, so a pop granted the cycle before flush produces no rd_valid.
  - RAM contents are not cleared.
- Back-to-back pops: each granted pop yields exactly one rd_valid pulse one cycle later. Continuous grants give continuous rd_valid.

Test Plan:
- Reset, then push 5, 6, 13, 7 on consecutive cycles:
  - wr_ack high each cycle.
  - RAM addr 0..3 written.
  - count=4, empty=0.
- Pop four times:
  - rd_ack high each cycle.
  - rd_valid high for 4 consecutive cycles, each one cycle after its rd_ack.
  - rd_data sequence 5, 6, 13, 7.
  - empty=1 afterwards.
- Fill with 16 pushes:
  - full=1, count=16.
  - The 17th wr_en gets wr_ack=0, and ram_we stays 0.
  - Then pop 16 words, checking FIFO order.
  - A further rd_en gets rd_ack=0 and no rd_valid follows.
- Wrap-around:
  - Push 12, pop 12, push 8 (wptr goes 12 -> 4 through the 15->0 wrap).
  - Pop 8 with rptr 12 -> 4; data returned in order.
- Contention: count=3, wr_en and rd_en held high for 4 cycles, starting with prio=0.
  - Grants alternate push, pop, push, pop.
  - count ends at 3.
- Mid-operation clear: assert flush (then separately rst) in the cycle after a pop's rd_ack, with count=5.
  - No rd_valid is produced.
  - count=0, empty=1.
  - The next push lands at RAM addr 0.

Source files
------------

// File: rtl/ram_sp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sp_fifo_ctrl
//  Description : FIFO controller wrapped around an external single-port RAM.
//                Arbitrates push/pop onto the one RAM port, holds pointers,
//                occupancy count and full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_sp_fifo_ctrl #(
  parameter int DW    = 5,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          rd_en,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          prio_q, prio_d;
  logic          rd_valid_q, rd_valid_d;

  logic          push_elig, pop_elig, push_gnt, pop_gnt;

  assign full  = (count_q == C_FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  // Arbitrate the single RAM port and compute next state for pointers/count.
  always_comb begin
    push_elig  = wr_en && !full;
    pop_elig   = rd_en && !empty;
    push_gnt   = 1'b0;
    pop_gnt    = 1'b0;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    prio_d     = prio_q;
    rd_valid_d = 1'b0;

    if (!rst && !flush) begin
      if (push_elig && pop_elig) begin
        // prio=0 favours the write side; flip so contention alternates
        push_gnt = !prio_q;
        pop_gnt  = prio_q;
        prio_d   = !prio_q;
      end else begin
        push_gnt = push_elig;
        pop_gnt  = pop_elig;
      end
    end

    if (push_gnt) begin
      wptr_d  = wptr_q + 1'b1;
      count_d = count_q + 1'b1;
    end
    if (pop_gnt) begin
      rptr_d     = rptr_q + 1'b1;
      count_d    = count_q - 1'b1;
      rd_valid_d = 1'b1;
    end

    // flush empties the FIFO but keeps the arbitration fairness state
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      rd_valid_d = 1'b0;
    end
  end

  assign wr_ack   = push_gnt;
  assign rd_ack   = pop_gnt;
  assign ram_we   = push_gnt;
  assign ram_addr = push_gnt ? wptr_q : rptr_q;
  assign ram_din  = wr_data;
  assign rd_data  = ram_dout;
  // A read already in flight is squashed by a clear in its data cycle
  assign rd_valid = rd_valid_q && !flush && !rst;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      prio_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      prio_q     <= prio_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_sp_fifo_ctrl
//  Description : Directed self-checking bench for ram_sp_fifo_ctrl with a
//                behavioural single-port RAM attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sp_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en;
  logic [4:0] wr_data;
  logic       wr_ack, rd_ack, rd_valid, ram_we, full, empty;
  logic [4:0] rd_data, ram_din, ram_dout;
  logic [3:0] ram_addr;
  logic [4:0] count;

  logic [4:0] mem [16];

  int         vectors = 0;
  int         miscompares = 0;
  logic [4:0] q [$];
  int         wp = 0;
  int         rp = 0;
  logic       pend = 1'b0;
  logic [4:0] pend_d = '0;

  always #5 clk = ~clk;

  // Synchronous-read single-port RAM
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  ram_sp_fifo_ctrl #(.DW(5), .AW(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_en(rd_en), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .count(count), .full(full), .empty(empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] d);
    wr_en = 1'b1; wr_data = d;
    #1;
    chk("push_wr_ack", wr_ack, 1);
    chk("push_ram_we", ram_we, 1);
    chk("push_ram_addr", ram_addr, wp[3:0]);
    chk("push_ram_din", ram_din, d);
    chk("push_rd_ack", rd_ack, 0);
    cyc();
    wr_en = 1'b0;
    q.push_back(d);
    wp = (wp + 1) % 16;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    #1;
    chk("pop_rd_ack", rd_ack, 1);
    chk("pop_ram_we", ram_we, 0);
    chk("pop_ram_addr", ram_addr, rp[3:0]);
    if (pend) begin
      chk("pop_rd_valid", rd_valid, 1);
      chk("pop_rd_data", rd_data, pend_d);
    end
    cyc();
    rd_en = 1'b0;
    pend = 1'b1;
    pend_d = q.pop_front();
    rp = (rp + 1) % 16;
  endtask

  task automatic drain();
    #1;
    if (pend) begin
      chk("drain_rd_valid", rd_valid, 1);
      chk("drain_rd_data", rd_data, pend_d);
    end
    pend = 1'b0;
    cyc();
    chk("drain_rd_valid_low", rd_valid, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    cyc(); cyc();

    // Reset state, with requests present that must not be granted
    wr_en = 1'b1; rd_en = 1'b1;
    #1;
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
    cyc();
    chk("rst_rd_valid", rd_valid, 0);

    // Basic push then pop
    push(5'd5); push(5'd6); push(5'd13); push(5'd7);
    chk("basic_count", count, 4);
    chk("basic_empty", empty, 0);
    pop(); pop(); pop(); pop();
    drain();
    chk("basic_empty_after", empty, 1);

    // Fill to full, overflow attempt, drain, underflow attempt
    for (int i = 0; i < 16; i++) push(5'((i * 3 + 2) % 32));
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    wr_en = 1'b1; wr_data = 5'd31;
    #1;
    chk("ovf_wr_ack", wr_ack, 0);
    chk("ovf_ram_we", ram_we, 0);
    cyc();
    wr_en = 1'b0;
    chk("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) pop();
    rd_en = 1'b1;
    #1;
    chk("udf_rd_ack", rd_ack, 0);
    chk("udf_last_valid", rd_valid, 1);
    chk("udf_last_data", rd_data, pend_d);
    pend = 1'b0;
    cyc();
    rd_en = 1'b0;
    chk("udf_no_valid", rd_valid, 0);
    chk("udf_empty", empty, 1);

    // Wrap-around from a clean reset
    rst = 1'b1; cyc(); rst = 1'b0;
    q.delete(); wp = 0; rp = 0;
    for (int i = 0; i < 12; i++) push(5'(i + 10));
    for (int i = 0; i < 12; i++) pop();
    drain();
    for (int i = 0; i < 8; i++) push(5'(i + 1));
    for (int i = 0; i < 8; i++) pop();
    drain();
    chk("wrap_empty", empty, 1);

    // Contention: count=3, both sides requesting for four cycles
    push(5'd1); push(5'd2); push(5'd3);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 5'd20;
    #1;
    chk("cont0_wr_ack", wr_ack, 1);
    chk("cont0_rd_ack", rd_ack, 0);
    chk("cont0_addr", ram_addr, wp[3:0]);
    cyc();
    q.push_back(5'd20); wp = (wp + 1) % 16; wr_data = 5'd21;
    #1;
    chk("cont1_wr_ack", wr_ack, 0);
    chk("cont1_rd_ack", rd_ack, 1);
    chk("cont1_addr", ram_addr, rp[3:0]);
    cyc();
    pend_d = q.pop_front(); rp = (rp + 1) % 16;
    #1;
    chk("cont2_wr_ack", wr_ack, 1);
    chk("cont2_rd_ack", rd_ack, 0);
    chk("cont2_addr", ram_addr, wp[3:0]);
    chk("cont2_rd_valid", rd_valid, 1);
    chk("cont2_rd_data", rd_data, pend_d);
    cyc();
    q.push_back(5'd21); wp = (wp + 1) % 16;
    #1;
    chk("cont3_wr_ack", wr_ack, 0);
    chk("cont3_rd_ack", rd_ack, 1);
    chk("cont3_addr", ram_addr, rp[3:0]);
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    pend = 1'b1; pend_d = q.pop_front(); rp = (rp + 1) % 16;
    drain();
    chk("cont_count", count, 3);

    // flush the cycle after a pop grant, count=5
    push(5'd8); push(5'd9);
    chk("flush_pre_count", count, 5);
    pop();
    flush = 1'b1;
    #1;
    chk("flush_no_valid", rd_valid, 0);
    chk("flush_wr_ack", wr_ack, 0);
    pend = 1'b0;
    cyc();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_no_valid2", rd_valid, 0);
    q.delete(); wp = 0; rp = 0;
    push(5'd9);

    // rst the cycle after a pop grant, count=5
    push(5'd10); push(5'd11); push(5'd12); push(5'd14);
    chk("rst2_pre_count", count, 5);
    pop();
    rst = 1'b1;
    #1;
    chk("rst2_no_valid", rd_valid, 0);
    pend = 1'b0;
    cyc();
    rst = 1'b0;
    chk("rst2_count", count, 0);
    chk("rst2_empty", empty, 1);
    chk("rst2_no_valid2", rd_valid, 0);
    q.delete(); wp = 0; rp = 0;
    push(5'd17);
    pop();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
